ysyx_23060236_ifu_fetch: RTL and testbench

- Instruction fetch unit: the producer side of the decode stage's `idu_valid`/`idu_ready` handshake, driving `in`, `pc` and `idu_valid`.
- Reads instruction words over an AXI4-Lite-style read channel with a single outstanding request and a one-entry output register.
- Predicts sequential PC+4. On `jump_wrong`/`jump_target` from the execute stage it redirects and discards wrong-path fetches.

---
 rtl/ysyx_23060236_ifu_fetch.sv | 154 +++++++++++++++
 tb/tb_ysyx_23060236_ifu_fetch.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060236_ifu_fetch.sv
// ---------------------------------------------------------------------------
// ysyx_23060236_ifu_fetch
//
// Instruction fetch unit. Issues one instruction read at a time over an
// AXI4-Lite-style read channel and presents each returned word to decode
// through a one-entry output register ({in, pc, idu_valid}). The next fetch
// address is predicted as PC+4. A redirect from execute (jump_wrong with
// jump_target) squashes the presented instruction and drops the data of any
// request already issued on the wrong path.
//
// Ports
//   clock        rising-edge clock for all state
//   reset        asynchronous, active-low reset
//   jump_wrong   redirect pulse from execute
//   jump_target  redirect address, used when jump_wrong=1
//   in, pc       instruction word and its address for decode
//   idu_valid    in/pc valid
//   idu_ready    decode accepts the presented instruction this cycle
//   araddr       read address          arvalid  read address valid
//   arready      address accepted      rdata    read data
//   rresp        read response (0=OK)  rvalid   read data valid
//   rready       fetch accepts data
//   fetch_err    sticky flag, set by any accepted non-OKAY response
// ---------------------------------------------------------------------------
module ysyx_23060236_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        jump_wrong,
  input  logic [31:0] jump_target,
  output logic [31:0] in,
  output logic [31:0] pc,
  output logic        idu_valid,
  input  logic        idu_ready,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic        fetch_err
);

  typedef enum logic {
    S_AR = 1'b0,
    S_R  = 1'b1
  } state_t;

  state_t      state_reg;
  logic [31:0] araddr_reg;
  logic [31:0] fetch_pc_reg;
  logic [31:0] fetch_pc_next;
  logic [31:0] in_reg;
  logic [31:0] pc_reg;
  logic        idu_valid_reg;
  logic        discard_reg;
  logic        fetch_err_reg;

  logic        ar_fire;
  logic        r_fire;
  logic        load;

  assign arvalid   = (state_reg == S_AR);
  // Data may be taken when the output slot is free or being emptied, or when
  // it is going to be thrown away anyway (stale request or redirect).
  assign rready    = (state_reg == S_R) &
                     (~idu_valid_reg | idu_ready | discard_reg | jump_wrong);
  assign ar_fire   = arvalid & arready;
  assign r_fire    = rvalid & rready;
  assign load      = r_fire & ~discard_reg & ~jump_wrong;

  assign araddr    = araddr_reg;
  assign in        = in_reg;
  assign pc        = pc_reg;
  assign idu_valid = idu_valid_reg;
  assign fetch_err = fetch_err_reg;

  // Next request address. A redirect wins over the sequential guess. When a
  // wrong-path request is finally accepted (discard already set), the
  // redirect target held in fetch_pc must not be overwritten by its +4.
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (jump_wrong) begin
      fetch_pc_next = jump_target;
    end else if (ar_fire && !discard_reg) begin
      fetch_pc_next = araddr_reg + 32'd4;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_AR;
      araddr_reg    <= RESET_PC;
      fetch_pc_reg  <= RESET_PC;
      in_reg        <= 32'h0;
      pc_reg        <= 32'h0;
      idu_valid_reg <= 1'b0;
      discard_reg   <= 1'b0;
      fetch_err_reg <= 1'b0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;

      // araddr only moves when a response completes, so an unaccepted
      // request is never altered, even by a redirect.
      case (state_reg)
        S_AR: begin
          if (ar_fire) begin
            state_reg <= S_R;
          end
        end
        S_R: begin
          if (r_fire) begin
            state_reg  <= S_AR;
            araddr_reg <= fetch_pc_next;
          end
        end
      endcase

      // discard marks the single outstanding (or pending) request as
      // wrong-path. In S_AR the pending request will complete later no matter
      // what, so it always needs draining. In S_R only if its data is not
      // being consumed this very cycle.
      if (jump_wrong) begin
        if (state_reg == S_AR) begin
          discard_reg <= 1'b1;
        end else begin
          discard_reg <= ~r_fire;
        end
      end else if (r_fire) begin
        discard_reg <= 1'b0;
      end

      // Output register: redirect squashes, a load replaces (also the entry
      // being accepted this cycle), otherwise an accepted entry empties.
      if (jump_wrong) begin
        idu_valid_reg <= 1'b0;
      end else if (load) begin
        in_reg        <= rdata;
        pc_reg        <= araddr_reg;
        idu_valid_reg <= 1'b1;
      end else if (idu_valid_reg && idu_ready) begin
        idu_valid_reg <= 1'b0;
      end

      // Errors count even on dropped data.
      if (r_fire && (rresp != 2'b00)) begin
        fetch_err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_ifu_fetch.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_23060236_ifu_fetch.
// A small memory model answers reads with rdata = ~address and configurable
// address/data wait states. Expected decode deliveries (pc values) are queued
// ahead of time and popped whenever decode accepts an instruction.
// ---------------------------------------------------------------------------
module tb_ysyx_23060236_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h3000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        jump_wrong;
  logic [31:0] jump_target;
  logic [31:0] in;
  logic [31:0] pc;
  logic        idu_valid;
  logic        idu_ready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        fetch_err;

  always #5 clock = ~clock;

  ysyx_23060236_ifu_fetch #(
    .RESET_PC (RESET_PC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .jump_wrong  (jump_wrong),
    .jump_target (jump_target),
    .in          (in),
    .pc          (pc),
    .idu_valid   (idu_valid),
    .idu_ready   (idu_ready),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .fetch_err   (fetch_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc;

  // memory model state
  int          ar_wait;
  int          r_delay;
  int          ar_cnt;
  int          r_cnt;
  logic        mem_busy;
  logic [31:0] mem_addr;
  logic [31:0] err_addr;

  // scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] ar_log[$];
  int          deliver_cyc[$];

  typedef struct {
    logic [31:0] target;
    int          aw;
    int          rd;
    int          n;
    logic [31:0] exp_last;
  } row_t;

  row_t rows[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One clock cycle. Called at the falling edge with decode-side inputs
  // already set; drives the memory side, records handshakes, and returns at
  // the next falling edge.
  task automatic step();
    logic        ar_hs;
    logic        r_hs;
    logic [31:0] e;
    arready = !mem_busy && (ar_cnt >= ar_wait);
    rvalid  = mem_busy && (r_cnt >= r_delay);
    rdata   = mem_busy ? ~mem_addr : 32'h0;
    rresp   = (mem_busy && (mem_addr == err_addr)) ? 2'b10 : 2'b00;
    #1;
    ar_hs = arvalid && arready;
    r_hs  = rvalid && rready;
    if (reset && idu_valid && idu_ready && !jump_wrong) begin
      checks++;
      $display("[%0t] deliver pc=%h in=%h", $time, pc, in);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_delivery: got pc=%h, want none", pc);
      end else begin
        e = exp_q.pop_front();
        if ((pc !== e) || (in !== ~e)) begin
          errors++;
          $display("FAIL delivery: got pc=%h in=%h, want pc=%h in=%h", pc, in, e, ~e);
        end
        deliver_cyc.push_back(cyc);
      end
    end
    if (reset) begin
      if (ar_hs) begin
        ar_log.push_back(araddr);
        mem_busy = 1'b1;
        mem_addr = araddr;
        r_cnt    = 0;
        ar_cnt   = 0;
      end else if (arvalid) begin
        ar_cnt++;
      end
      if (r_hs) begin
        mem_busy = 1'b0;
      end else if (mem_busy && !ar_hs) begin
        r_cnt++;
      end
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic run_until_empty(input int bound, input string name);
    int n;
    n = 0;
    while ((exp_q.size() > 0) && (n < bound)) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending deliveries, want 0", name, exp_q.size());
    end
  endtask

  // Asserts reset at a falling edge, checks the asynchronous reset values,
  // then releases it two cycles later.
  task automatic do_reset();
    reset      = 1'b0;
    jump_wrong = 1'b0;
    #1;
    chk("rst_idu_valid", 32'(idu_valid), 32'h0);
    chk("rst_in", in, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_fetch_err", 32'(fetch_err), 32'h0);
    chk("rst_araddr", araddr, RESET_PC);
    chk("rst_rready", 32'(rready), 32'h0);
    mem_busy = 1'b0;
    ar_cnt   = 0;
    r_cnt    = 0;
    arready  = 1'b0;
    rvalid   = 1'b0;
    exp_q.delete();
    ar_log.delete();
    deliver_cyc.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    int n;
    logic [31:0] last;

    rows[0] = '{32'h3000_0100, 0, 0, 3, 32'h3000_0108};
    rows[1] = '{32'hFFFF_FFF8, 0, 1, 4, 32'h0000_0004};
    rows[2] = '{32'h0000_0102, 2, 0, 3, 32'h0000_010A};
    rows[3] = '{32'h8000_0000, 1, 2, 3, 32'h8000_0008};

    reset       = 1'b0;
    jump_wrong  = 1'b0;
    jump_target = 32'h0;
    idu_ready   = 1'b0;
    arready     = 1'b0;
    rvalid      = 1'b0;
    rdata       = 32'h0;
    rresp       = 2'b00;
    ar_wait     = 0;
    r_delay     = 0;
    err_addr    = 32'h0000_0001;
    mem_busy    = 1'b0;
    mem_addr    = 32'h0;
    cyc         = 0;
    @(negedge clock);
    do_reset();

    // Zero-wait streaming with decode always ready.
    idu_ready = 1'b1;
    exp_q.push_back(32'h3000_0000);
    exp_q.push_back(32'h3000_0004);
    exp_q.push_back(32'h3000_0008);
    run_until_empty(40, "stream");
    chk("stream_ar0", ar_log[0], 32'h3000_0000);
    chk("stream_ar1", ar_log[1], 32'h3000_0004);
    chk("stream_ar2", ar_log[2], 32'h3000_0008);
    chk("first_valid_cycle", 32'(deliver_cyc[0]), 32'd2);
    chk("second_valid_cycle", 32'(deliver_cyc[1]), 32'd4);
    chk("third_valid_cycle", 32'(deliver_cyc[2]), 32'd6);

    // Decode stalls: output held, next read data held by rready=0.
    idu_ready = 1'b0;
    n = 0;
    while (!idu_valid && (n < 20)) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(idu_valid), 32'h1);
      chk("stall_pc", pc, 32'h3000_000C);
      chk("stall_in", in, ~32'h3000_000C);
      step();
    end
    chk("stall_rdata_held", {30'h0, rvalid, rready}, 32'h2);
    idu_ready = 1'b1;
    exp_q.push_back(32'h3000_000C);
    exp_q.push_back(32'h3000_0010);
    exp_q.push_back(32'h3000_0014);
    run_until_empty(40, "unstall");
    idu_ready = 1'b0;

    // Redirect table: jump while stalled, then stream from the target.
    for (int r = 0; r < 4; r++) begin
      ar_wait     = rows[r].aw;
      r_delay     = rows[r].rd;
      jump_wrong  = 1'b1;
      jump_target = rows[r].target;
      exp_q.delete();
      step();
      jump_wrong = 1'b0;
      chk("row_squash", 32'(idu_valid), 32'h0);
      for (int k = 0; k < rows[r].n; k++) begin
        exp_q.push_back(rows[r].target + 32'(4 * k));
      end
      idu_ready = 1'b1;
      run_until_empty(200, "row");
      last = (deliver_cyc.size() > 0) ? pc : 32'hxxxx_xxxx;
      chk("row_last_pc", last, rows[r].exp_last);
      idu_ready = 1'b0;
    end

    // Redirect in S_R while the response is late.
    ar_wait = 0;
    r_delay = 3;
    do_reset();
    idu_ready = 1'b1;
    step();
    step();
    jump_wrong  = 1'b1;
    jump_target = 32'h3000_0100;
    step();
    jump_wrong = 1'b0;
    exp_q.push_back(32'h3000_0100);
    exp_q.push_back(32'h3000_0104);
    run_until_empty(60, "late_redirect");
    chk("late_ar1", ar_log[1], 32'h3000_0100);
    chk("late_ar2", ar_log[2], 32'h3000_0104);

    // Redirect while an address is waiting for arready.
    ar_wait = 3;
    r_delay = 0;
    do_reset();
    idu_ready = 1'b1;
    exp_q.push_back(32'h3000_0000);
    exp_q.push_back(32'h3000_0004);
    run_until_empty(60, "ar_stall_pre");
    chk("pending_arvalid", 32'(arvalid), 32'h1);
    chk("pending_araddr", araddr, 32'h3000_0008);
    jump_wrong  = 1'b1;
    jump_target = 32'h3000_0200;
    step();
    jump_wrong = 1'b0;
    chk("pending_hold1", araddr, 32'h3000_0008);
    chk("pending_hold1_valid", 32'(arvalid), 32'h1);
    step();
    chk("pending_hold2", araddr, 32'h3000_0008);
    exp_q.push_back(32'h3000_0200);
    exp_q.push_back(32'h3000_0204);
    run_until_empty(60, "ar_stall_post");
    chk("pending_ar_drained", ar_log[2], 32'h3000_0008);
    chk("pending_ar_target", ar_log[3], 32'h3000_0200);

    // Redirect in the same cycle as rvalid.
    ar_wait = 0;
    r_delay = 0;
    do_reset();
    idu_ready = 1'b1;
    step();
    jump_wrong  = 1'b1;
    jump_target = 32'h3000_0300;
    step();
    jump_wrong = 1'b0;
    chk("samecyc_valid", 32'(idu_valid), 32'h0);
    chk("samecyc_arvalid", 32'(arvalid), 32'h1);
    chk("samecyc_araddr", araddr, 32'h3000_0300);
    exp_q.push_back(32'h3000_0300);
    exp_q.push_back(32'h3000_0304);
    run_until_empty(40, "samecyc");
    chk("samecyc_ar1", ar_log[1], 32'h3000_0300);

    // Error response on one beat.
    err_addr = 32'h3000_0004;
    do_reset();
    idu_ready = 1'b1;
    exp_q.push_back(32'h3000_0000);
    run_until_empty(20, "err_pre");
    chk("err_clear_before", 32'(fetch_err), 32'h0);
    exp_q.push_back(32'h3000_0004);
    exp_q.push_back(32'h3000_0008);
    run_until_empty(40, "err");
    chk("err_set", 32'(fetch_err), 32'h1);
    idu_ready = 1'b0;
    step();
    step();
    step();
    chk("err_sticky", 32'(fetch_err), 32'h1);

    // Reset in the middle of a read.
    err_addr    = 32'h0000_0001;
    r_delay     = 3;
    jump_wrong  = 1'b1;
    jump_target = 32'h3000_0400;
    step();
    jump_wrong = 1'b0;
    n = 0;
    while ((arvalid || rvalid) && (n < 12)) begin
      step();
      n++;
    end
    chk("midreq_in_s_r", 32'(arvalid), 32'h0);
    chk("midreq_err_before", 32'(fetch_err), 32'h1);
    do_reset();
    r_delay   = 0;
    idu_ready = 1'b1;
    exp_q.push_back(RESET_PC);
    run_until_empty(20, "after_reset");
    chk("after_reset_ar0", ar_log[0], RESET_PC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
